// File: rtl/clockctrl_cfg_sequencer.sv
// AXI4-Lite master: writes and reads back the four clockctrl registers after reset, then serves host commands.
// Zero-wait slave gives a 3-cycle latency from command accept to rsp_valid; one transaction outstanding, all VALIDs held until handshake.
module clockctrl_cfg_sequencer #(
    parameter logic [31:0] INIT_R0            = 32'h00000001,
    parameter logic [31:0] INIT_R1            = 32'h00000002,
    parameter logic [31:0] INIT_R2            = 32'h00000003,
    parameter logic [31:0] INIT_R3            = 32'h00000004,
    parameter int          C_M_AXI_ADDR_WIDTH = 4
) (
    input  logic                          ACLK,
    input  logic                          ARESETN,
    input  logic                          cmd_valid,
    output logic                          cmd_ready,
    input  logic                          cmd_write,
    input  logic [1:0]                    cmd_idx,
    input  logic [31:0]                   cmd_wdata,
    output logic                          rsp_valid,
    output logic [31:0]                   rsp_rdata,
    output logic                          rsp_err,
    output logic                          init_done,
    output logic                          init_fail,
    output logic [C_M_AXI_ADDR_WIDTH-1:0] M_AXI_AWADDR,
    output logic [2:0]                    M_AXI_AWPROT,
    output logic                          M_AXI_AWVALID,
    input  logic                          M_AXI_AWREADY,
    output logic [31:0]                   M_AXI_WDATA,
    output logic [3:0]                    M_AXI_WSTRB,
    output logic                          M_AXI_WVALID,
    input  logic                          M_AXI_WREADY,
    input  logic [1:0]                    M_AXI_BRESP,
    input  logic                          M_AXI_BVALID,
    output logic                          M_AXI_BREADY,
    output logic [C_M_AXI_ADDR_WIDTH-1:0] M_AXI_ARADDR,
    output logic [2:0]                    M_AXI_ARPROT,
    output logic                          M_AXI_ARVALID,
    input  logic                          M_AXI_ARREADY,
    input  logic [31:0]                   M_AXI_RDATA,
    input  logic [1:0]                    M_AXI_RRESP,
    input  logic                          M_AXI_RVALID,
    output logic                          M_AXI_RREADY
);

    typedef enum logic [2:0] {INIT_WR, INIT_RD, IDLE, WR, RD, RSP} state_t;

    state_t      state, state_nxt;
    logic [1:0]  idx, txn_idx, start_idx;
    logic [31:0] wdata, start_wdata;
    logic        awvalid, wvalid, arvalid;
    logic        aw_done, w_done, ar_done, wr_busy, rd_busy;
    logic        aw_fire, w_fire, b_fire, ar_fire, r_fire;
    logic        cmd_accept, start_wr, start_rd;

    function automatic logic [31:0] init_val(input logic [1:0] i);
        logic [31:0] v;
        case (i)
            2'd0: v = INIT_R0;
            2'd1: v = INIT_R1;
            2'd2: v = INIT_R2;
            2'd3: v = INIT_R3;
        endcase
        return v;
    endfunction

    assign M_AXI_AWADDR  = C_M_AXI_ADDR_WIDTH'({txn_idx, 2'b00});
    assign M_AXI_ARADDR  = C_M_AXI_ADDR_WIDTH'({txn_idx, 2'b00});
    assign M_AXI_AWPROT  = 3'b000;
    assign M_AXI_ARPROT  = 3'b000;
    assign M_AXI_WSTRB   = 4'hF;
    assign M_AXI_WDATA   = wdata;
    assign M_AXI_AWVALID = awvalid;
    assign M_AXI_WVALID  = wvalid;
    assign M_AXI_ARVALID = arvalid;
    // B is only accepted once both AW and W have completed, even if the slave answers early.
    assign M_AXI_BREADY  = wr_busy & aw_done & w_done;
    assign M_AXI_RREADY  = rd_busy & ar_done;

    assign aw_fire = awvalid & M_AXI_AWREADY;
    assign w_fire  = wvalid & M_AXI_WREADY;
    assign ar_fire = arvalid & M_AXI_ARREADY;
    assign b_fire  = M_AXI_BREADY & M_AXI_BVALID;
    assign r_fire  = M_AXI_RREADY & M_AXI_RVALID;

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            state <= INIT_WR;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        cmd_ready   = (state == IDLE);
        cmd_accept  = cmd_valid & (state == IDLE);
        start_wr    = ((state == INIT_WR) & ~wr_busy) | (cmd_accept & cmd_write);
        start_rd    = ((state == INIT_RD) & ~rd_busy) | (cmd_accept & ~cmd_write);
        start_idx   = (state == IDLE) ? cmd_idx : idx;
        start_wdata = (state == IDLE) ? cmd_wdata : init_val(idx);
        case (state)
            INIT_WR: if (b_fire && idx == 2'd3) state_nxt = INIT_RD;
            INIT_RD: if (r_fire && idx == 2'd3) state_nxt = IDLE;
            IDLE:    if (cmd_valid) state_nxt = cmd_write ? WR : RD;
            WR:      if (b_fire) state_nxt = RSP;
            RD:      if (r_fire) state_nxt = RSP;
            RSP:     state_nxt = IDLE;
            default: state_nxt = INIT_WR;
        endcase
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            idx       <= 2'd0;
            txn_idx   <= 2'd0;
            wdata     <= 32'd0;
            awvalid   <= 1'b0;
            wvalid    <= 1'b0;
            arvalid   <= 1'b0;
            aw_done   <= 1'b0;
            w_done    <= 1'b0;
            ar_done   <= 1'b0;
            wr_busy   <= 1'b0;
            rd_busy   <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_rdata <= 32'd0;
            rsp_err   <= 1'b0;
            init_done <= 1'b0;
            init_fail <= 1'b0;
        end else begin
            rsp_valid <= 1'b0;
            if (aw_fire) begin awvalid <= 1'b0; aw_done <= 1'b1; end
            if (w_fire)  begin wvalid  <= 1'b0; w_done  <= 1'b1; end
            if (ar_fire) begin arvalid <= 1'b0; ar_done <= 1'b1; end
            if (b_fire)  wr_busy <= 1'b0;
            if (r_fire)  rd_busy <= 1'b0;
            if (start_wr) begin
                awvalid <= 1'b1;
                wvalid  <= 1'b1;
                aw_done <= 1'b0;
                w_done  <= 1'b0;
                wr_busy <= 1'b1;
                txn_idx <= start_idx;
                wdata   <= start_wdata;
            end
            if (start_rd) begin
                arvalid <= 1'b1;
                ar_done <= 1'b0;
                rd_busy <= 1'b1;
                txn_idx <= start_idx;
            end
            // idx wraps 3->0 at the end of the write pass, ready for the readback pass.
            if (state == INIT_WR && b_fire) begin
                idx <= idx + 2'd1;
                if (M_AXI_BRESP != 2'b00) init_fail <= 1'b1;
            end
            if (state == INIT_RD && r_fire) begin
                idx <= idx + 2'd1;
                if (M_AXI_RDATA != init_val(idx) || M_AXI_RRESP != 2'b00) init_fail <= 1'b1;
                if (idx == 2'd3) init_done <= 1'b1;
            end
            if ((state == WR && b_fire) || (state == RD && r_fire)) begin
                rsp_valid <= 1'b1;
                rsp_rdata <= (state == RD) ? M_AXI_RDATA : 32'd0;
                rsp_err   <= (state == RD) ? (M_AXI_RRESP != 2'b00) : (M_AXI_BRESP != 2'b00);
            end
        end
    end

endmodule

// File: tb/tb_clockctrl_cfg_sequencer.sv
// Directed and randomized bench: AXI4-Lite slave with selectable ready delays, protocol monitor and register-file model.
module tb_clockctrl_cfg_sequencer;

    logic        ACLK = 1'b0;
    logic        ARESETN;
    logic        cmd_valid, cmd_ready, cmd_write;
    logic [1:0]  cmd_idx;
    logic [31:0] cmd_wdata;
    logic        rsp_valid, rsp_err, init_done, init_fail;
    logic [31:0] rsp_rdata;
    logic [3:0]  M_AXI_AWADDR, M_AXI_ARADDR;
    logic [2:0]  M_AXI_AWPROT, M_AXI_ARPROT;
    logic        M_AXI_AWVALID, M_AXI_AWREADY, M_AXI_WVALID, M_AXI_WREADY;
    logic [31:0] M_AXI_WDATA, M_AXI_RDATA;
    logic [3:0]  M_AXI_WSTRB;
    logic [1:0]  M_AXI_BRESP, M_AXI_RRESP;
    logic        M_AXI_BVALID, M_AXI_BREADY, M_AXI_ARVALID, M_AXI_ARREADY;
    logic        M_AXI_RVALID, M_AXI_RREADY;

    always #5 ACLK = ~ACLK;

    clockctrl_cfg_sequencer dut (
        .ACLK(ACLK), .ARESETN(ARESETN),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_idx(cmd_idx), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .init_done(init_done), .init_fail(init_fail),
        .M_AXI_AWADDR(M_AXI_AWADDR), .M_AXI_AWPROT(M_AXI_AWPROT),
        .M_AXI_AWVALID(M_AXI_AWVALID), .M_AXI_AWREADY(M_AXI_AWREADY),
        .M_AXI_WDATA(M_AXI_WDATA), .M_AXI_WSTRB(M_AXI_WSTRB),
        .M_AXI_WVALID(M_AXI_WVALID), .M_AXI_WREADY(M_AXI_WREADY),
        .M_AXI_BRESP(M_AXI_BRESP), .M_AXI_BVALID(M_AXI_BVALID), .M_AXI_BREADY(M_AXI_BREADY),
        .M_AXI_ARADDR(M_AXI_ARADDR), .M_AXI_ARPROT(M_AXI_ARPROT),
        .M_AXI_ARVALID(M_AXI_ARVALID), .M_AXI_ARREADY(M_AXI_ARREADY),
        .M_AXI_RDATA(M_AXI_RDATA), .M_AXI_RRESP(M_AXI_RRESP),
        .M_AXI_RVALID(M_AXI_RVALID), .M_AXI_RREADY(M_AXI_RREADY)
    );

    int checks = 0;
    int errors = 0;
    int prot_viol = 0;
    int rsp_pulses = 0;
    int mode = 0;               // 0 zero-wait, 1 WREADY late, 2 AWREADY late, 3 random
    bit bad_r2 = 1'b0;
    bit rd_err3 = 1'b0;
    logic [31:0] mem [4];
    logic [31:0] model [4];
    logic [3:0]  wlog_a [$];
    logic [31:0] wlog_d [$];
    logic [3:0]  rlog_a [$];

    bit          aw_got, w_got, ar_seen, ar_pend, b_hs, r_hs;
    bit          p_awv, p_wv, p_arv, p_awf, p_wf, p_arf;
    logic [3:0]  aw_a, ar_a, p_awa, p_ara;
    logic [31:0] w_d, p_wd;
    int          dcnt;

    // Slave and protocol monitor: at each falling edge, decide what fires on the next rising edge.
    always @(negedge ACLK) begin
        if (!ARESETN) begin
            M_AXI_AWREADY = 0; M_AXI_WREADY = 0; M_AXI_BVALID = 0; M_AXI_BRESP = 0;
            M_AXI_ARREADY = 0; M_AXI_RVALID = 0; M_AXI_RRESP = 0; M_AXI_RDATA = 0;
            aw_got = 0; w_got = 0; ar_seen = 0; ar_pend = 0; b_hs = 0; r_hs = 0; dcnt = 0;
            p_awv = 0; p_wv = 0; p_arv = 0; p_awf = 0; p_wf = 0; p_arf = 0;
        end else begin
            if (p_awv && !p_awf && (!M_AXI_AWVALID || M_AXI_AWADDR !== p_awa)) prot_viol++;
            if (p_wv && !p_wf && (!M_AXI_WVALID || M_AXI_WDATA !== p_wd)) prot_viol++;
            if (p_arv && !p_arf && (!M_AXI_ARVALID || M_AXI_ARADDR !== p_ara)) prot_viol++;
            if ((p_awf && M_AXI_AWVALID) || (p_wf && M_AXI_WVALID) || (p_arf && M_AXI_ARVALID)) prot_viol++;
            if (M_AXI_BREADY && !(aw_got && w_got)) prot_viol++;
            if (M_AXI_RREADY && !ar_seen) prot_viol++;
            if (cmd_ready && !init_done) prot_viol++;
            if (M_AXI_AWPROT !== 3'd0 || M_AXI_ARPROT !== 3'd0 || M_AXI_WSTRB !== 4'hF) prot_viol++;

            if (b_hs) begin M_AXI_BVALID = 0; aw_got = 0; w_got = 0; dcnt = 0; end
            if (r_hs) begin M_AXI_RVALID = 0; ar_seen = 0; end
            if (aw_got && w_got && !M_AXI_BVALID && (mode != 3 || $urandom_range(0, 1) == 1)) begin
                mem[aw_a[3:2]] = w_d;
                wlog_a.push_back(aw_a);
                wlog_d.push_back(w_d);
                M_AXI_BVALID = 1; M_AXI_BRESP = 2'b00;
            end
            if (ar_pend && (mode != 3 || $urandom_range(0, 1) == 1)) begin
                ar_pend = 0;
                rlog_a.push_back(ar_a);
                M_AXI_RDATA = (bad_r2 && ar_a[3:2] == 2'd2) ? 32'hDEADBEEF : mem[ar_a[3:2]];
                M_AXI_RRESP = (rd_err3 && ar_a[3:2] == 2'd3) ? 2'b10 : 2'b00;
                M_AXI_RVALID = 1;
            end
            if ((mode == 1 && aw_got && !w_got) || (mode == 2 && w_got && !aw_got)) dcnt++;
            M_AXI_AWREADY = !aw_got && (mode == 0 || mode == 1 || (mode == 2 && w_got && dcnt >= 5)
                                        || (mode == 3 && $urandom_range(0, 1) == 1));
            M_AXI_WREADY  = !w_got && (mode == 0 || mode == 2 || (mode == 1 && aw_got && dcnt >= 5)
                                        || (mode == 3 && $urandom_range(0, 1) == 1));
            M_AXI_ARREADY = !ar_seen && (mode != 3 || $urandom_range(0, 1) == 1);

            p_awf = M_AXI_AWVALID && M_AXI_AWREADY;
            p_wf  = M_AXI_WVALID && M_AXI_WREADY;
            p_arf = M_AXI_ARVALID && M_AXI_ARREADY;
            if (p_awf) begin aw_got = 1; aw_a = M_AXI_AWADDR; end
            if (p_wf)  begin w_got = 1; w_d = M_AXI_WDATA; end
            if (p_arf) begin ar_seen = 1; ar_pend = 1; ar_a = M_AXI_ARADDR; end
            b_hs = M_AXI_BVALID && M_AXI_BREADY;
            r_hs = M_AXI_RVALID && M_AXI_RREADY;
            p_awv = M_AXI_AWVALID; p_awa = M_AXI_AWADDR;
            p_wv  = M_AXI_WVALID;  p_wd  = M_AXI_WDATA;
            p_arv = M_AXI_ARVALID; p_ara = M_AXI_ARADDR;
        end
    end

    always @(negedge ACLK) if (rsp_valid === 1'b1) rsp_pulses++;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_ctl"}, 32'({M_AXI_AWVALID, M_AXI_WVALID, M_AXI_BREADY, M_AXI_ARVALID, M_AXI_RREADY,
                                  cmd_ready, rsp_valid, init_done, init_fail}), 32'd0);
        check({tag, "_rdata"}, rsp_rdata, 32'd0);
        check({tag, "_err"}, 32'(rsp_err), 32'd0);
    endtask

    task automatic wait_init(input string tag);
        int n = 0;
        while (!init_done && n < 3000) begin @(negedge ACLK); n++; end
        check({tag, "_init_done"}, 32'(init_done), 32'd1);
    endtask

    task automatic wait_ready(input string tag);
        int n = 0;
        @(negedge ACLK);
        while (!cmd_ready && n < 300) begin @(negedge ACLK); n++; end
        check({tag, "_cmd_ready"}, 32'(cmd_ready), 32'd1);
    endtask

    task automatic do_cmd(input string tag, input bit wr, input logic [1:0] idx, input logic [31:0] d,
                          input logic [31:0] exp_rd, input logic exp_err, input bit chk_lat);
        int n = 0;
        int p0;
        wait_ready(tag);
        if (!cmd_ready) return;
        cmd_valid = 1; cmd_write = wr; cmd_idx = idx; cmd_wdata = d;
        p0 = rsp_pulses;
        @(posedge ACLK);
        #1 cmd_valid = 0;
        do begin @(negedge ACLK); n++; end while (!rsp_valid && n < 300);
        check({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd1);
        if (chk_lat) check({tag, "_latency"}, 32'(n), 32'd3);
        check({tag, "_rdata"}, rsp_rdata, exp_rd);
        check({tag, "_err"}, 32'(rsp_err), 32'(exp_err));
        repeat (2) @(negedge ACLK);
        check({tag, "_pulses"}, 32'(rsp_pulses - p0), 32'd1);
    endtask

    initial begin
        ARESETN = 0; cmd_valid = 0; cmd_write = 0; cmd_idx = 0; cmd_wdata = 0;
        for (int i = 0; i < 4; i++) mem[i] = 32'd0;
        #3 check_reset("rst0");
        repeat (2) @(negedge ACLK);
        ARESETN = 1;

        // Init with zero-wait slave
        wait_init("A");
        check("A_fail", 32'(init_fail), 32'd0);
        check("A_wcount", 32'(wlog_a.size()), 32'd4);
        check("A_rcount", 32'(rlog_a.size()), 32'd4);
        for (int i = 0; i < 4 && i < wlog_a.size() && i < rlog_a.size(); i++) begin
            check($sformatf("A_waddr%0d", i), 32'(wlog_a[i]), 32'(i * 4));
            check($sformatf("A_wdata%0d", i), wlog_d[i], 32'(i + 1));
            check($sformatf("A_raddr%0d", i), 32'(rlog_a[i]), 32'(i * 4));
        end
        check("A_proto", 32'(prot_viol), 32'd0);
        for (int i = 0; i < 4; i++) model[i] = 32'(i + 1);

        // Basic write / read
        do_cmd("B_wr", 1, 2'd1, 32'hA5A5A5A5, 32'd0, 1'b0, 1);
        model[1] = 32'hA5A5A5A5;
        do_cmd("B_rd", 0, 2'd1, 32'd0, model[1], 1'b0, 1);

        // Skewed AW / W handshakes
        mode = 1;
        do_cmd("C_wdly", 1, 2'd2, 32'h12345678, 32'd0, 1'b0, 0);
        model[2] = 32'h12345678;
        mode = 2;
        do_cmd("C_awdly", 1, 2'd0, 32'h0BADF00D, 32'd0, 1'b0, 0);
        model[0] = 32'h0BADF00D;
        mode = 0;
        do_cmd("C_rd2", 0, 2'd2, 32'd0, model[2], 1'b0, 1);
        do_cmd("C_rd0", 0, 2'd0, 32'd0, model[0], 1'b0, 1);
        check("C_proto", 32'(prot_viol), 32'd0);

        // Error response on read of register 3, then a normal command
        rd_err3 = 1;
        do_cmd("D_slverr", 0, 2'd3, 32'd0, model[3], 1'b1, 1);
        rd_err3 = 0;
        do_cmd("D_wr3", 1, 2'd3, 32'hCAFEF00D, 32'd0, 1'b0, 1);
        model[3] = 32'hCAFEF00D;
        do_cmd("D_rd3", 0, 2'd3, 32'd0, model[3], 1'b0, 1);

        // Random commands against a random-ready slave
        mode = 3;
        for (int k = 0; k < 40; k++) begin
            bit          wr;
            logic [1:0]  ix;
            logic [31:0] d;
            wr = 1'($urandom_range(0, 1));
            ix = 2'($urandom_range(0, 3));
            d  = $urandom;
            do_cmd($sformatf("E%0d", k), wr, ix, d, wr ? 32'd0 : model[ix], 1'b0, 0);
            if (wr) model[ix] = d;
        end
        check("E_proto", 32'(prot_viol), 32'd0);

        // Bad readback of register 2 during init
        mode = 0;
        bad_r2 = 1;
        @(negedge ACLK); #2 ARESETN = 0; #1 check_reset("F_rst");
        repeat (3) @(negedge ACLK);
        ARESETN = 1;
        wait_init("F");
        check("F_fail", 32'(init_fail), 32'd1);
        @(negedge ACLK);
        check("F_cmd_ready", 32'(cmd_ready), 32'd1);
        bad_r2 = 0;
        for (int i = 0; i < 4; i++) model[i] = 32'(i + 1);
        do_cmd("F_rd2", 0, 2'd2, 32'd0, model[2], 1'b0, 1);

        // Reset while AWVALID is pending
        do_cmd("G_rd1", 0, 2'd1, 32'd0, model[1], 1'b0, 1);
        mode = 2;
        wait_ready("G");
        cmd_valid = 1; cmd_write = 1; cmd_idx = 2'd2; cmd_wdata = 32'h77778888;
        @(posedge ACLK);
        #1 cmd_valid = 0;
        begin
            int n = 0;
            do begin @(negedge ACLK); n++; end while (!M_AXI_AWVALID && n < 50);
        end
        check("G_awvalid", 32'(M_AXI_AWVALID), 32'd1);
        #2 ARESETN = 0;
        #1 check_reset("G_rst");
        repeat (3) @(negedge ACLK);
        wlog_a.delete(); wlog_d.delete();
        ARESETN = 1;
        wait_init("G");
        check("G_fail", 32'(init_fail), 32'd0);
        check("G_wcount", 32'(wlog_a.size()), 32'd4);
        if (wlog_a.size() > 0) begin
            check("G_waddr0", 32'(wlog_a[0]), 32'd0);
            check("G_wdata0", wlog_d[0], 32'd1);
        end
        check("G_proto", 32'(prot_viol), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
